// File: rtl/apb_param_ram_pkg.sv
// Shared types and constants for the parametrised APB RAM.
// Provides the FSM state encoding, the wait-counter width and a lane-count helper.
// Imported by the interface-level top and the storage array.
package apb_ram_pkg;

  typedef enum logic {IDLE, ACCESS} state_t;

  // Wait counter is sized for the largest supported WAIT_STATES (15).
  localparam int CNT_W = 4;

  // Number of byte lanes (= PSTRB width) for a given data width.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_param_ram_if.sv
// APB4 bus bundle between the bridge (master) and a memory peripheral (slave).
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB from master; PREADY/PRDATA/PSLVERR from slave.
// Clock and reset are carried as plain ports on the modules, not in the bundle.
interface apb_param_ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_param_ram_array.sv
// DEPTH x DATA_WIDTH storage: byte-enabled synchronous write, registered synchronous read.
// Ports: wr_en/wr_idx/wr_strb/wr_dat write port; rd_en/rd_clr/rd_idx read port; rd_dat output.
// Latency: read data valid one edge after rd_en; only the read register is reset, never the memory.
module apb_ram_array
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [strb_width(DATA_WIDTH)-1:0]   wr_strb,
  input  logic [DATA_WIDTH-1:0]               wr_dat,
  input  logic                                rd_en,
  input  logic                                rd_clr,
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic [DATA_WIDTH-1:0]               rd_dat
);
  localparam int BYTES = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
    end
  end

  // Clear takes priority so an errored read or an abort returns zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_dat <= '0;
    else if (rd_clr) rd_dat <= '0;
    else if (rd_en)  rd_dat <= mem[rd_idx];
  end
endmodule

// File: rtl/apb_param_ram.sv
// APB4 slave RAM with configurable width, depth, wait states, byte strobes and PSLVERR.
// Ports: PCLK, PRESETn (async, active-low), bus = APB slave modport.
// Latency 2 + WAIT_STATES cycles per transfer; PREADY held low for WAIT_STATES access cycles.
module apb_param_ram
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_param_ram_if.slave   bus
);
  localparam int BYTES = strb_width(DATA_WIDTH);
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic             err_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  addr_err;
  logic                  setup;
  logic                  complete;
  logic                  abort;
  logic                  pready;
  logic                  pslverr;

  // Masking the low address bits avoids a negative-range slice when BYTES = 1.
  assign word_addr = bus.PADDR >> LSB;
  assign addr_err  = ((bus.PADDR & ADDR_WIDTH'(BYTES - 1)) != '0) ||
                     (word_addr >= ADDR_WIDTH'(DEPTH));
  assign setup     = (state_q == IDLE) && bus.PSEL && !bus.PENABLE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    abort    = 1'b0;
    pready   = 1'b1;
    pslverr  = 1'b0;
    case (state_q)
      IDLE: begin
        // PENABLE without a preceding setup cycle falls through here untouched.
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        pready = (cnt_q == '0);
        if (!bus.PSEL) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.PENABLE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            complete = 1'b1;
            pslverr  = err_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        idx_q <= word_addr[IDX_W-1:0];
        wr_q  <= bus.PWRITE;
        err_q <= addr_err;
      end
    end
  end

  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;

  // Reads fetch at the setup edge; writes commit at the completing edge with live PWDATA/PSTRB.
  apb_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .wr_en   (complete && wr_q && !err_q),
    .wr_idx  (idx_q),
    .wr_strb (bus.PSTRB),
    .wr_dat  (bus.PWDATA),
    .rd_en   (setup && !bus.PWRITE && !addr_err),
    .rd_clr  ((setup && !bus.PWRITE && addr_err) || abort),
    .rd_idx  (word_addr[IDX_W-1:0]),
    .rd_dat  (bus.PRDATA)
  );
endmodule
